// File: rtl/dct_arb_pkg.sv
// Shared types and helpers for the DCT row-pass arbiter.
//   arb_state_e : arbiter FSM state (IDLE, or block granted to r0 / r1)
//   SIZE_*      : block size encodings carried on rX_size / o_size
//   rows_of()   : rows in a block for a given size code (4 << size)
//   DEF_*       : default lane count and lane widths
package dct_arb_pkg;

  localparam int unsigned DEF_LANES = 32;
  localparam int unsigned DEF_W0    = 19;
  localparam int unsigned DEF_W1    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_4  = 2'd0;
  localparam logic [1:0] SIZE_8  = 2'd1;
  localparam logic [1:0] SIZE_16 = 2'd2;
  localparam logic [1:0] SIZE_32 = 2'd3;

  function automatic logic [5:0] rows_of(input logic [1:0] size);
    logic [5:0] rows;
    unique case (size)
      SIZE_4:  rows = 6'd4;
      SIZE_8:  rows = 6'd8;
      SIZE_16: rows = 6'd16;
      SIZE_32: rows = 6'd32;
      default: rows = 6'd4;
    endcase
    return rows;
  endfunction

endpackage

// File: rtl/dct_arb_oreg.sv
// Output register stage of the DCT row-pass arbiter.
// Captures an accepted row (widening r1 lanes by sign extension) and holds
// every output stable while o_valid && !o_ready.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load               a row is accepted this cycle (only when not stalled)
//   in_pass            0 = take in_data0, 1 = take sign-extended in_data1
//   in_size/row/last   block attributes of the accepted row
//   in_data0/in_data1  r0 row (LANES*W0) / r1 row (LANES*W1)
//   o_ready            downstream accepts the presented row
//   o_valid..o_data    registered row to the 1D transform
module dct_arb_oreg
  import dct_arb_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned W0    = DEF_W0,
  parameter int unsigned W1    = DEF_W1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                in_pass,
  input  logic [1:0]          in_size,
  input  logic [4:0]          in_row,
  input  logic                in_last,
  input  logic [LANES*W0-1:0] in_data0,
  input  logic [LANES*W1-1:0] in_data1,
  input  logic                o_ready,
  output logic                o_valid,
  output logic                o_pass,
  output logic [1:0]          o_size,
  output logic [4:0]          o_row,
  output logic                o_last,
  output logic [LANES*W0-1:0] o_data
);

  logic [LANES*W0-1:0] data1_ext;
  logic [LANES*W0-1:0] data_sel;

  always_comb begin
    data1_ext = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      data1_ext[k*W0 +: W0] = {{(W0-W1){in_data1[k*W1 + W1 - 1]}}, in_data1[k*W1 +: W1]};
    end
    data_sel = in_pass ? data1_ext : in_data0;
  end

  // Payload only changes on load; load never happens while stalled, so a
  // presented row is held until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_pass  <= 1'b0;
      o_size  <= 2'd0;
      o_row   <= 5'd0;
      o_last  <= 1'b0;
      o_data  <= '0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_pass  <= in_pass;
      o_size  <= in_size;
      o_row   <= in_row;
      o_last  <= in_last;
      o_data  <= data_sel;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dct_pass_arb.sv
// DCT row-pass arbiter: grants whole blocks of rows to either the transpose
// return (r0) or the prediction-error rows (r1) and forwards them through a
// single output register to the 1D transform.
// Requests are sampled only in IDLE or on the last-row accept of a block, so
// back-to-back blocks run with no idle cycle.
// Configuration: define DCT_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise r0 has fixed priority.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   r0_req/size/valid/data    requester 0 block request and rows (W0 lanes)
//   r0_ready                  r0 row accepted this cycle
//   r1_req/size/valid/data    requester 1 block request and rows (W1 lanes)
//   r1_ready                  r1 row accepted this cycle
//   o_valid/o_ready           output row handshake
//   o_pass/size/row/last/data row source, block size, row index, last flag, data
module dct_pass_arb
  import dct_arb_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned W0    = DEF_W0,
  parameter int unsigned W1    = DEF_W1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_req,
  input  logic [1:0]          r0_size,
  input  logic                r0_valid,
  input  logic [LANES*W0-1:0] r0_data,
  output logic                r0_ready,
  input  logic                r1_req,
  input  logic [1:0]          r1_size,
  input  logic                r1_valid,
  input  logic [LANES*W1-1:0] r1_data,
  output logic                r1_ready,
  output logic                o_valid,
  input  logic                o_ready,
  output logic                o_pass,
  output logic [1:0]          o_size,
  output logic [4:0]          o_row,
  output logic                o_last,
  output logic [LANES*W0-1:0] o_data
);

  arb_state_e state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [1:0] size_q, size_d;

  logic acc0, acc1, acc, at_last, sample;
  logic grant0, grant1, prefer0;

`ifdef DCT_ARB_RR_EN
  // Winner of the last contested arbitration was r1 (reset: r1, so r0 wins first).
  logic last1_q, last1_d;
  assign prefer0 = last1_q;
`else
  assign prefer0 = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    size_d  = size_q;
`ifdef DCT_ARB_RR_EN
    last1_d = last1_q;
`endif
    grant0  = 1'b0;
    grant1  = 1'b0;

    // Gated by rst so readies are low for the whole reset window.
    r0_ready = !rst && (state_q == G0) && (!o_valid || o_ready);
    r1_ready = !rst && (state_q == G1) && (!o_valid || o_ready);
    acc0     = r0_ready && r0_valid;
    acc1     = r1_ready && r1_valid;
    acc      = acc0 || acc1;
    at_last  = ({1'b0, row_q} == (rows_of(size_q) - 6'd1));
    sample   = (state_q == IDLE) || (acc && at_last);

    if (acc) begin
      row_d = row_q + 5'd1;
    end

    if (sample) begin
      grant0 = r0_req && (!r1_req || prefer0);
      grant1 = r1_req && !grant0;
      row_d  = 5'd0;
      if (grant0) begin
        state_d = G0;
        size_d  = r0_size;
      end else if (grant1) begin
        state_d = G1;
        size_d  = r1_size;
      end else begin
        state_d = IDLE;
      end
`ifdef DCT_ARB_RR_EN
      // Only contested grants move the round-robin pointer.
      if (r0_req && r1_req) begin
        last1_d = grant1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 5'd0;
      size_q  <= 2'd0;
`ifdef DCT_ARB_RR_EN
      last1_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      size_q  <= size_d;
`ifdef DCT_ARB_RR_EN
      last1_q <= last1_d;
`endif
    end
  end

  dct_arb_oreg #(
    .LANES (LANES),
    .W0    (W0),
    .W1    (W1)
  ) u_oreg (
    .clk      (clk),
    .rst      (rst),
    .load     (acc),
    .in_pass  (acc1),
    .in_size  (size_q),
    .in_row   (row_q),
    .in_last  (at_last),
    .in_data0 (r0_data),
    .in_data1 (r1_data),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_pass   (o_pass),
    .o_size   (o_size),
    .o_row    (o_row),
    .o_last   (o_last),
    .o_data   (o_data)
  );

endmodule

// File: tb/tb_dct_pass_arb.sv
// Self-checking bench for dct_pass_arb: block-level reference model feeds a
// scoreboard queue; a monitor pops and compares every transferred row, checks
// hold-under-stall, zero-ready-under-stall and one-cycle latency.
module tb_dct_pass_arb;
  import dct_arb_pkg::*;

  localparam int LANES = 32;
  localparam int W0    = 19;
  localparam int W1    = 16;
  localparam int DW0   = LANES * W0;
  localparam int DW1   = LANES * W1;

  typedef logic [DW0-1:0] d0_t;
  typedef logic [DW1-1:0] d1_t;
  typedef struct packed {
    logic       pass;
    logic [1:0] size;
    logic [4:0] row;
    logic       last;
    d0_t        data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r0_req = 1'b0, r0_valid = 1'b0, r0_ready;
  logic [1:0] r0_size = 2'd0;
  d0_t        r0_data = '0;
  logic       r1_req = 1'b0, r1_valid = 1'b0, r1_ready;
  logic [1:0] r1_size = 2'd0;
  d1_t        r1_data = '0;
  logic       o_valid, o_ready = 1'b1, o_pass, o_last;
  logic [1:0] o_size;
  logic [4:0] o_row;
  d0_t        o_data;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  int   stall_trig = 0;
  exp_t exp_q[$];
  int   stamp_q[$];
  int   out_cyc[$];
  d0_t  src0_q[$];
  d1_t  src1_q[$];
`ifdef DCT_ARB_RR_EN
  bit   prefer0 = 1'b1;
`endif

  dct_pass_arb #(
    .LANES (LANES),
    .W0    (W0),
    .W1    (W1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .r0_req   (r0_req),
    .r0_size  (r0_size),
    .r0_valid (r0_valid),
    .r0_data  (r0_data),
    .r0_ready (r0_ready),
    .r1_req   (r1_req),
    .r1_size  (r1_size),
    .r1_valid (r1_valid),
    .r1_data  (r1_data),
    .r1_ready (r1_ready),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_pass   (o_pass),
    .o_size   (o_size),
    .o_row    (o_row),
    .o_last   (o_last),
    .o_data   (o_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic d0_t rnd0();
    d0_t v;
    for (int k = 0; k < LANES; k++) v[k*W0 +: W0] = W0'($urandom);
    return v;
  endfunction

  function automatic d1_t rnd1();
    d1_t v;
    for (int k = 0; k < LANES; k++) v[k*W1 +: W1] = W1'($urandom);
    return v;
  endfunction

  // Reference widening: signed W1 value assigned to a signed W0 variable.
  function automatic d0_t sext(input d1_t x);
    d0_t r;
    logic signed [W1-1:0] a;
    logic signed [W0-1:0] b;
    for (int k = 0; k < LANES; k++) begin
      a = x[k*W1 +: W1];
      b = a;
      r[k*W0 +: W0] = b;
    end
    return r;
  endfunction

  // Monitor: scoreboard pop, stall hold, ready-under-stall, latency.
  initial begin
    exp_t cur, hv, e;
    bit   held = 1'b0;
    int   seen = 0;
    int   force_low = 0;
    int   s;
    forever begin
      @(negedge clk);
      cur = {o_pass, o_size, o_row, o_last, o_data};
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) check("hold", 1024'(cur), 1024'(hv));
        if (o_valid && !held) begin
          if (stamp_q.size() == 0) check("latency_nostamp", 1024'(1), 1024'(0));
          else begin
            s = stamp_q.pop_front();
            check("latency", 1024'(cyc), 1024'(s + 1));
          end
        end
        if (o_valid && o_ready) begin
          out_cyc.push_back(cyc);
          if (exp_q.size() == 0) check("unexpected_row", 1024'(cur), 1024'(0));
          else begin
            e = exp_q.pop_front();
            check("row", 1024'(cur), 1024'(e));
          end
        end else if (o_valid) begin
          check("stall_ready", 1024'({r0_ready, r1_ready}), 1024'(0));
        end
        held = o_valid && !o_ready;
        hv = cur;
      end
      @(posedge clk);
      #1;
      if (stall_trig != seen) begin
        seen = stall_trig;
        force_low = 3;
      end
      if (force_low > 0) begin
        o_ready = 1'b0;
        force_low--;
      end else begin
        o_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic push_blk(input bit pass, input logic [1:0] sz, input d0_t rows[$]);
    exp_t e;
    for (int i = 0; i < rows.size(); i++) begin
      e.pass = pass;
      e.size = sz;
      e.row  = 5'(i);
      e.last = (i == rows.size() - 1);
      e.data = rows[i];
      exp_q.push_back(e);
    end
  endtask

  // Requesters drop req once they see their first ready (mid-block drop).
  task automatic src0(input logic [1:0] sz, input int n, input int vprob);
    int got = 0;
    int t = 0;
    bit gr = 1'b0;
    r0_req = 1'b1;
    r0_size = sz;
    while (got < n && t < 3000) begin
      r0_valid = ($urandom_range(0, 99) < vprob);
      r0_data = src0_q[0];
      @(negedge clk);
      if (r0_ready) gr = 1'b1;
      if (r0_ready && r0_valid) begin
        stamp_q.push_back(cyc);
        void'(src0_q.pop_front());
        got++;
      end
      @(posedge clk);
      #1;
      if (gr) r0_req = 1'b0;
      t++;
    end
    r0_valid = 1'b0;
    r0_req = 1'b0;
    if (got < n) check("src0_timeout", 1024'(got), 1024'(n));
  endtask

  task automatic src1(input logic [1:0] sz, input int n, input int vprob);
    int got = 0;
    int t = 0;
    bit gr = 1'b0;
    r1_req = 1'b1;
    r1_size = sz;
    while (got < n && t < 3000) begin
      r1_valid = ($urandom_range(0, 99) < vprob);
      r1_data = src1_q[0];
      @(negedge clk);
      if (r1_ready) gr = 1'b1;
      if (r1_ready && r1_valid) begin
        stamp_q.push_back(cyc);
        void'(src1_q.pop_front());
        got++;
      end
      @(posedge clk);
      #1;
      if (gr) r1_req = 1'b0;
      t++;
    end
    r1_valid = 1'b0;
    r1_req = 1'b0;
    if (got < n) check("src1_timeout", 1024'(got), 1024'(n));
  endtask

  // One arbitration round: requesters raise req together from an idle arbiter.
  task automatic do_round(input bit use0, input bit use1, input logic [1:0] sz0,
                          input logic [1:0] sz1, input int vprob,
                          input d0_t lane0_r0, input d1_t lane0_r1, input bit force_lane);
    d0_t b0[$];
    d0_t b1[$];
    d1_t d1;
    int  n0 = 4 << sz0;
    int  n1 = 4 << sz1;
    bit  first0;
    int  t = 0;
    if (use0) for (int i = 0; i < n0; i++) begin
      b0.push_back(rnd0());
      if (force_lane && i == 0) b0[0][W0-1:0] = lane0_r0[W0-1:0];
      src0_q.push_back(b0[i]);
    end
    if (use1) for (int i = 0; i < n1; i++) begin
      d1 = rnd1();
      if (force_lane && i == 0) d1[W1-1:0] = lane0_r1[W1-1:0];
      src1_q.push_back(d1);
      b1.push_back(sext(d1));
    end
    first0 = use0;
    if (use0 && use1) begin
`ifdef DCT_ARB_RR_EN
      first0 = prefer0;
      prefer0 = !first0;
`else
      first0 = 1'b1;
`endif
    end
    if (first0) begin
      push_blk(1'b0, sz0, b0);
      if (use1) push_blk(1'b1, sz1, b1);
    end else begin
      push_blk(1'b1, sz1, b1);
      if (use0) push_blk(1'b0, sz0, b0);
    end
    fork
      begin
        if (use0) src0(sz0, n0, vprob);
      end
      begin
        if (use1) src1(sz1, n1, vprob);
      end
    join
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", 1024'(exp_q.size()), 1024'(0));
  endtask

  initial begin
    d0_t  d;
    exp_t e;
    int   got;
    int   t;
    d0_t  z0;
    d1_t  z1;
    z0 = '0;
    z1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 1024'({o_valid, o_pass, o_size, o_row, o_last, o_data, r0_ready,
                                r1_ready}), 1024'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Valid without grant must be ignored.
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_grant", 1024'({o_valid, r0_ready, r1_ready}), 1024'(0));
      @(posedge clk);
      #1;
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;

    // r1 size 0, full throughput.
    do_round(1'b0, 1'b1, 2'd0, 2'd0, 100, z0, z1, 1'b0);

    // Simultaneous size-1 pair twice, checking back-to-back output.
    repeat (2) begin
      out_cyc.delete();
      do_round(1'b1, 1'b1, 2'd1, 2'd1, 100, z0, z1, 1'b0);
      check("pair_count", 1024'(out_cyc.size()), 1024'(16));
      if (out_cyc.size() == 16) check("pair_gap", 1024'(out_cyc[15] - out_cyc[0]), 1024'(15));
    end

    // Sign extension corner lanes.
    d = '0;
    d[W0-1:0] = 19'h40001;
    z1[W1-1:0] = 16'h8000;
    do_round(1'b1, 1'b1, 2'd0, 2'd0, 100, d, z1, 1'b1);
    z1 = '0;

    // Three-cycle downstream stall mid-block.
    fork
      do_round(1'b1, 1'b0, 2'd2, 2'd0, 100, z0, z1, 1'b0);
      begin
        repeat (7) @(posedge clk);
        #1;
        stall_trig++;
      end
    join

    // Reset after 10 accepted rows of a size-3 r0 block.
    r0_req = 1'b1;
    r0_size = 2'd3;
    r0_valid = 1'b1;
    got = 0;
    t = 0;
    r0_data = rnd0();
    while (got < 10 && t < 200) begin
      @(negedge clk);
      if (r0_ready && r0_valid) begin
        stamp_q.push_back(cyc);
        e.pass = 1'b0;
        e.size = 2'd3;
        e.row = 5'(got);
        e.last = 1'b0;
        e.data = r0_data;
        exp_q.push_back(e);
        got++;
      end
      @(posedge clk);
      #1;
      if (got > 0) r0_req = 1'b0;
      if (got >= 10) r0_valid = 1'b0;
      else r0_data = rnd0();
      t++;
    end
    check("rst_blk_rows", 1024'(got), 1024'(10));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    r0_valid = 1'b1;
    @(negedge clk);
    check("rst_ready_gate", 1024'({r0_ready, r1_ready}), 1024'(0));
    @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 1024'({o_valid, o_pass, o_size, o_row, o_last, o_data, r0_ready,
                                r1_ready}), 1024'(0));
    check("rst_drain", 1024'(exp_q.size()), 1024'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    r0_valid = 1'b0;
    stamp_q.delete();
`ifdef DCT_ARB_RR_EN
    prefer0 = 1'b1;
`endif
    do_round(1'b0, 1'b1, 2'd0, 2'd0, 100, z0, z1, 1'b0);

    // Randomized rounds with random valid and ready.
    rdy_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      int u;
      u = $urandom_range(1, 3);
      do_round(u[0], u[1], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               $urandom_range(50, 100), z0, z1, 1'b0);
    end
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dct_pass_arb.md
DCT_PASS_ARB -- requirements
Module: dct_pass_arb

Interface
REQ-001 SHALL have the following parameters:
- LANES, 32, coefficient lanes per row.
- W0, 19, first-requester (transpose-return) lane width.
- W1, 16, second-requester (prediction-error) lane width.

REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports, in order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- r0_req  in  1  requester 0 (transpose return) asks for a block.
- r0_size  in  2  block size, 0/1/2/3 = 4/8/16/32 rows.
- r0_valid  in  1  r0 row valid.
- r0_data  in  LANES*W0  r0 row, signed lanes.
- r0_ready  out  1  r0 row accepted this cycle.
- r1_req  in  1  requester 1 (pe rows) asks for a block.
- r1_size  in  2  as r0_size.
- r1_valid  in  1  r1 row valid.
- r1_data  in  LANES*W1  r1 row, signed lanes.
- r1_ready  out  1  r1 row accepted.
- o_valid  out  1  row valid to the 1D transform.
- o_ready  in  1  transform accepts row.
- o_pass  out  1  0 = row from r0, 1 = row from r1.
- o_size  out  2  size of the current block.
- o_row  out  5  row index within the block.
- o_last  out  1  last row of the block.
- o_data  out  LANES*W0  selected row, signed.

Function
REQ-003 SHALL implement FSM states IDLE, G0 and G1, where G0/G1 mean the block is granted to r0/r1.
REQ-004 SHALL sample r0_req/r1_req only in IDLE or on the cycle the last row of a block is accepted; request changes mid-block SHALL be ignored.
REQ-005 SHALL arbitrate by fixed priority: r0 over r1 when both request.
REQ-006 SHALL latch the granted requester's size at grant; rows per block = 4 << size.
REQ-007 SHALL define row accept as gX_state && rX_valid && rX_ready, with rX_ready = gX_state && (!o_valid || o_ready); the non-granted ready SHALL be 0.
REQ-008 SHALL provide one output register stage: an accepted row appears on o_* the next cycle, and o_* SHALL hold stable while o_valid && !o_ready.
REQ-009 SHALL sign-extend r1 lanes to W0 (lane k: replicate bit W1-1); r0 lanes SHALL pass unchanged.
REQ-010 SHALL increment the row counter per accept, cleared at grant; o_last SHALL be 1 when o_row == rows-1.
REQ-011 On the last-row accept SHALL move directly to G0/G1 if a request is pending (zero idle cycles), else to IDLE.
REQ-012 SHALL keep rX_valid without a grant harmless: no accept, no output.

Reset
REQ-013 While rst is asserted SHALL give: state IDLE, row counter 0, o_valid 0, o_pass 0, o_size 0, o_row 0, o_last 0, o_data 0, r0_ready 0, r1_ready 0.
REQ-014 Reset mid-block SHALL abandon the block; the first post-reset grant SHALL start at row 0.

Configuration
REQ-015 With macro DCT_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins, with last-served reset to r1 so r0 wins first.
REQ-016 Without DCT_ARB_RR_EN, REQ-005 fixed priority SHALL apply and no last-served state SHALL exist.

Structure
REQ-017 Package dct_arb_pkg SHALL hold:
- the state enum {IDLE, G0, G1};
- size encodings;
- the size-to-rows function;
- default LANES/W0/W1 constants.
REQ-018 The output register with stall hold and sign extension SHALL be sub-module dct_arb_oreg; FSM and counter SHALL stay in dct_pass_arb.

Verification
REQ-019 Bench SHALL cover:
- r1_req=1, size=0, 4 valid rows, o_ready=1 -> 4 outputs, o_pass=1, o_row 0..3, o_last on row 3, 1-cycle latency.
- r0_req and r1_req rise together, both size=1 -> 8 r0 rows, then 8 r1 rows with no gap; with DCT_ARB_RR_EN, a second simultaneous pair yields r1 first.
- r1 lane value 16'h8000 -> o_data lane = 19'h78000; r0 lane 19'h40001 -> unchanged.
- o_ready low 3 cycles mid-block -> o_* held, rX_ready=0, no row lost or duplicated.
- rst pulse after row 10 of a size=3 block -> all outputs 0, IDLE; new grant starts o_row=0.
- r1_req dropped mid-block -> block still completes all rows.
